// File: rtl/fifo_mw_sram_merge_if.sv
// Bus bundle for the multi-writer merge FIFO: writer lanes, reader side and status.
// FIFO_MW_ALMOST_FULL_EN adds the almost_full status line.
interface fifo_mw_sram_merge_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int WR_NUM     = 4,
  parameter int ID_WIDTH   = 2
);
  logic [WR_NUM-1:0]            push;
  logic [DATA_WIDTH*WR_NUM-1:0] data_in;
  logic [WR_NUM-1:0]            push_ack;
  logic                         pop;
  logic [DATA_WIDTH-1:0]        data_out;
  logic [ID_WIDTH-1:0]          src_id;
  logic                         empty;
  logic                         full;
  logic [ADDR_WIDTH:0]          count;
`ifdef FIFO_MW_ALMOST_FULL_EN
  logic                         almost_full;
`endif

  // Producers/consumer side drives requests; FIFO side answers with acks, data and status.
  modport master (
    output push, data_in, pop,
    input  push_ack, data_out, src_id, empty, full, count
`ifdef FIFO_MW_ALMOST_FULL_EN
    , input almost_full
`endif
  );

  modport slave (
    input  push, data_in, pop,
    output push_ack, data_out, src_id, empty, full, count
`ifdef FIFO_MW_ALMOST_FULL_EN
    , output almost_full
`endif
  );
endinterface

// File: rtl/fifo_mw_sram_merge.sv
// Multi-writer single-reader merge FIFO with a round-robin write arbiter; each word keeps its lane ID.
// Optional feature macro: FIFO_MW_ALMOST_FULL_EN (adds combinational almost_full).
module fifo_mw_sram_merge #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int WR_NUM     = 4,
  parameter int ID_WIDTH   = 2,
  parameter int AF_MARGIN  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Reset,
  fifo_mw_sram_merge_if.slave    bus
);
  localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0]    mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [ID_WIDTH-1:0]   src_id_q;
  logic                  empty;
  logic                  full;
  logic                  pop_ok;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [WR_NUM-1:0]     grant_vec;
  logic [DATA_WIDTH-1:0] grant_data;

  assign empty  = (count == '0);
  assign full   = (count == (ADDR_WIDTH+1)'(RAM_DEPTH));
  assign pop_ok = bus.pop && !empty && !Reset;

  // Round-robin scan starting at rr_ptr; nothing is granted while full or clearing.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (rst_n && !full && !Reset) begin
      for (int k = 0; k < WR_NUM; k++) begin
        idx = (int'(rr_ptr) + k) % WR_NUM;
        if (!grant_valid && bus.push[idx]) begin
          grant_valid = 1'b1;
          grant_id    = ID_WIDTH'(idx);
        end
      end
    end
    grant_vec  = grant_valid ? (WR_NUM'(1) << grant_id) : '0;
    grant_data = bus.data_in[DATA_WIDTH*grant_id +: DATA_WIDTH];
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (grant_valid) begin
      mem[wr_ptr] <= {grant_id, grant_data};
    end
  end

  // Pointers, occupancy and the registered read port; the synchronous clear keeps data_out/src_id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      data_out_q <= '0;
      src_id_q   <= '0;
    end else if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (grant_valid) begin
        wr_ptr <= (wr_ptr == ADDR_WIDTH'(RAM_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
        rr_ptr <= ID_WIDTH'((int'(grant_id) + 1) % WR_NUM);
      end
      if (pop_ok) begin
        data_out_q <= mem[rd_ptr][DATA_WIDTH-1:0];
        src_id_q   <= mem[rd_ptr][ENTRY_W-1:DATA_WIDTH];
        rd_ptr     <= (rd_ptr == ADDR_WIDTH'(RAM_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({grant_valid, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.push_ack = grant_vec;
  assign bus.data_out = data_out_q;
  assign bus.src_id   = src_id_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count;

`ifdef FIFO_MW_ALMOST_FULL_EN
  assign bus.almost_full = (count >= (ADDR_WIDTH+1)'(RAM_DEPTH - AF_MARGIN));
`endif
endmodule

// File: tb/tb_fifo_mw_sram_merge.sv
// Self-checking bench for fifo_mw_sram_merge: directed scenarios plus randomized traffic against a queue model.
// Honours FIFO_MW_ALMOST_FULL_EN when the design is built with it.
module tb_fifo_mw_sram_merge;
  localparam int DW = 64, AW = 4, DEPTH = 16, WN = 4, IW = 2, AFM = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  fifo_mw_sram_merge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WR_NUM(WN), .ID_WIDTH(IW)) bus ();

  fifo_mw_sram_merge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
    .WR_NUM(WN), .ID_WIDTH(IW), .AF_MARGIN(AFM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {lane, word}, last granted lane, expected read port, per-lane offers.
  logic [IW+DW-1:0] q[$];
  int               last_g;
  logic [DW-1:0]    exp_dout;
  logic [IW-1:0]    exp_sid;
  logic [DW-1:0]    lane_data [WN];
  bit               rand_data;

  function automatic int model_grant();
    if (!rst_n || Reset || q.size() == DEPTH) return -1;
    for (int k = 1; k <= WN; k++) begin
      int l;
      l = (last_g + k) % WN;
      if (bus.push[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic [WN-1:0] exp_ack();
    int g;
    g = model_grant();
    return (g < 0) ? '0 : (WN'(1) << g);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < WN; i++) bus.data_in[DW*i +: DW] = lane_data[i];
  endtask

  // One clock edge: the model applies the same cycle's inputs, then the producers refresh offers.
  task automatic advance();
    int g;
    bit do_pop;
    logic [IW+DW-1:0] head;
    g      = model_grant();
    do_pop = bus.pop && (q.size() != 0) && !Reset;
    @(posedge clk);
    if (Reset) begin
      q.delete();
      last_g = WN - 1;
    end else begin
      if (do_pop) begin
        head     = q.pop_front();
        exp_sid  = head[IW+DW-1:DW];
        exp_dout = head[DW-1:0];
      end
      if (g >= 0) begin
        q.push_back({IW'(g), lane_data[g]});
        last_g       = g;
        lane_data[g] = rand_data ? {$urandom, $urandom} : lane_data[g] + 1;
      end
    end
    #1;
    drive_data();
  endtask

  task automatic test_reset();
    bus.push  = '0;
    bus.pop   = 1'b0;
    for (int i = 0; i < WN; i++) lane_data[i] = '0;
    drive_data();
    q.delete();
    last_g   = WN - 1;
    exp_dout = '0;
    exp_sid  = '0;
    rand_data = 1'b0;
    #12;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== '0 || bus.push_ack !== '0) begin
      errors++;
      $display("[TB] FAIL reset_status: empty=%b full=%b count=%0d ack=%b, want 1 0 0 0000",
               bus.empty, bus.full, bus.count, bus.push_ack);
    end
    checks++;
    if (bus.data_out !== '0 || bus.src_id !== '0) begin
      errors++;
      $display("[TB] FAIL reset_read: data_out=%h src_id=%0d, want 0 0", bus.data_out, bus.src_id);
    end
`ifdef FIFO_MW_ALMOST_FULL_EN
    checks++;
    if (bus.almost_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_af: got %b want 0", bus.almost_full);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < WN; i++) lane_data[i] = DW'(32'h100 + i);
    drive_data();
    bus.push = '1;
    bus.pop  = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      checks++;
      if (bus.push_ack !== ((c < DEPTH) ? (WN'(1) << (c % WN)) : WN'(0))) begin
        errors++;
        $display("[TB] FAIL fill_ack c=%0d: got %b", c, bus.push_ack);
      end
      checks++;
      if (bus.count !== (AW+1)'(q.size()) || bus.full !== (c >= DEPTH) || bus.empty !== (c == 0)) begin
        errors++;
        $display("[TB] FAIL fill_status c=%0d: count=%0d full=%b empty=%b, want count %0d",
                 c, bus.count, bus.full, bus.empty, q.size());
      end
`ifdef FIFO_MW_ALMOST_FULL_EN
      checks++;
      if (bus.almost_full !== (c >= DEPTH - AFM)) begin
        errors++;
        $display("[TB] FAIL fill_af c=%0d: got %b want %b", c, bus.almost_full, (c >= DEPTH - AFM));
      end
`endif
      advance();
    end
  endtask

  task automatic test_drain();
    bus.push = '0;
    bus.pop  = 1'b1;
    for (int c = 0; c <= DEPTH; c++) begin
      advance();
      checks++;
      if (c < DEPTH && (bus.data_out !== DW'(32'h100 + (c % WN) + c / WN) || bus.src_id !== IW'(c % WN))) begin
        errors++;
        $display("[TB] FAIL drain_data c=%0d: got %h/%0d want %h/%0d", c, bus.data_out, bus.src_id,
                 32'h100 + (c % WN) + c / WN, c % WN);
      end else if (bus.data_out !== exp_dout || bus.src_id !== exp_sid) begin
        errors++;
        $display("[TB] FAIL drain_hold c=%0d: got %h/%0d want %h/%0d", c, bus.data_out, bus.src_id,
                 exp_dout, exp_sid);
      end
      checks++;
      if (bus.count !== (AW+1)'((c < DEPTH) ? DEPTH - 1 - c : 0) || bus.empty !== (c >= DEPTH - 1)) begin
        errors++;
        $display("[TB] FAIL drain_count c=%0d: count=%0d empty=%b", c, bus.count, bus.empty);
      end
`ifdef FIFO_MW_ALMOST_FULL_EN
      checks++;
      if (bus.almost_full !== (q.size() >= DEPTH - AFM)) begin
        errors++;
        $display("[TB] FAIL drain_af c=%0d: got %b want %b", c, bus.almost_full, q.size() >= DEPTH - AFM);
      end
`endif
    end
    bus.pop = 1'b0;
  endtask

  task automatic test_single_lane();
    rand_data = 1'b1;
    bus.push  = 4'b0100;
    bus.pop   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.push_ack !== 4'b0100 || bus.count !== (AW+1)'((c == 0) ? 0 : 1)) begin
        errors++;
        $display("[TB] FAIL single_lane c=%0d: ack=%b count=%0d, want 0100 %0d", c, bus.push_ack,
                 bus.count, (c == 0) ? 0 : 1);
      end
      advance();
      checks++;
      if (c > 0 && (bus.src_id !== 2'd2 || bus.data_out !== exp_dout)) begin
        errors++;
        $display("[TB] FAIL single_lane_data c=%0d: got %h/%0d want %h/2", c, bus.data_out,
                 bus.src_id, exp_dout);
      end
    end
    bus.push = '0;
    advance();
    bus.pop = 1'b0;
  endtask

  task automatic test_full_pop_push();
    bus.push = '1;
    bus.pop  = 1'b0;
    for (int c = 0; c < 40 && q.size() < DEPTH; c++) advance();
    checks++;
    if (bus.full !== 1'b1 || q.size() != DEPTH) begin
      errors++;
      $display("[TB] FAIL fpp_full: full=%b model=%0d want 1/%0d", bus.full, q.size(), DEPTH);
    end
    bus.push = 4'b0010;
    bus.pop  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.push_ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL fpp_ack_full: got %b want 0000", bus.push_ack);
    end
    advance();
    bus.pop = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.push_ack !== 4'b0010 || bus.count !== 5'd15) begin
      errors++;
      $display("[TB] FAIL fpp_ack_next: ack=%b count=%0d want 0010 15", bus.push_ack, bus.count);
    end
    advance();
    bus.push = '0;
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fpp_refill: count=%0d full=%b want 16 1", bus.count, bus.full);
    end
    bus.pop = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      advance();
      checks++;
      if (bus.data_out !== exp_dout || bus.src_id !== exp_sid) begin
        errors++;
        $display("[TB] FAIL fpp_drain c=%0d: got %h/%0d want %h/%0d", c, bus.data_out, bus.src_id,
                 exp_dout, exp_sid);
      end
    end
    bus.pop = 1'b0;
  endtask

  task automatic test_sync_reset();
    logic [DW-1:0] held;
    bus.push = 4'b0001;
    for (int c = 0; c < 6; c++) advance();
    bus.push = '0;
    bus.pop  = 1'b1;
    advance();
    held     = exp_dout;
    bus.push = '1;
    Reset    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.push_ack !== '0 || bus.count !== 5'd5) begin
      errors++;
      $display("[TB] FAIL sreset_ack: ack=%b count=%0d want 0000 5", bus.push_ack, bus.count);
    end
    advance();
    Reset   = 1'b0;
    bus.pop = 1'b0;
    checks++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.data_out !== held) begin
      errors++;
      $display("[TB] FAIL sreset_state: count=%0d empty=%b data=%h want 0 1 %h", bus.count, bus.empty,
               bus.data_out, held);
    end
    @(negedge clk);
    checks++;
    if (bus.push_ack !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL sreset_rr: got %b want 0001", bus.push_ack);
    end
    bus.push = '0;
    Reset    = 1'b1;
    advance();
    Reset = 1'b0;
  endtask

  task automatic test_random();
    logic [WN-1:0] pending;
    rand_data = 1'b1;
    for (int c = 0; c < 400; c++) begin
      pending  = bus.push & ~exp_ack();
      bus.push = pending | WN'($urandom);
      bus.pop  = ($urandom_range(0, 99) < 45);
      Reset    = ($urandom_range(0, 99) < 2);
      @(negedge clk);
      checks++;
      if (bus.push_ack !== exp_ack()) begin
        errors++;
        $display("[TB] FAIL rand_ack c=%0d: got %b want %b", c, bus.push_ack, exp_ack());
      end
      checks++;
      if (bus.count !== (AW+1)'(q.size()) || bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH)) begin
        errors++;
        $display("[TB] FAIL rand_status c=%0d: count=%0d empty=%b full=%b want count %0d", c,
                 bus.count, bus.empty, bus.full, q.size());
      end
`ifdef FIFO_MW_ALMOST_FULL_EN
      checks++;
      if (bus.almost_full !== (q.size() >= DEPTH - AFM)) begin
        errors++;
        $display("[TB] FAIL rand_af c=%0d: got %b", c, bus.almost_full);
      end
`endif
      advance();
      checks++;
      if (bus.data_out !== exp_dout || bus.src_id !== exp_sid) begin
        errors++;
        $display("[TB] FAIL rand_data c=%0d: got %h/%0d want %h/%0d", c, bus.data_out, bus.src_id,
                 exp_dout, exp_sid);
      end
    end
    Reset    = 1'b0;
    bus.push = '0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_single_lane();
    test_full_pop_push();
    test_sync_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
